control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle instruction sequencer that drives the 16-bit control word (CTRWRD) and constant (Cin) into the existing register-file/ALU datapath.
- Consumes the datapath status flags V/C/N/Z.
- Fetches 16-bit instructions over a req/ack instruction port and sequences data-memory accesses over a req/ack data port.
- It is the producer side of the CTRWRD interface, which the datapath consumes.

Parameters:
PC_W, 8, program counter / instruction address width
RESET_VECTOR, 0, PC value loaded on reset

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
CTRWRD  out  16  datapath control word {DA[15:13],AA[12:10],BA[9:7],MB[6],FS[5:2],MD[1],RW[0]}
Cin  out  16  constant to datapath B-mux, zero-extended IR[5:0]
V,C,N,Z  in  1 each  datapath status, combinational for the current CTRWRD
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= PC)
imem_data  in  16  instruction, valid when imem_ack=1
imem_ack  in  1  fetch complete
dmem_req  out  1  data access request; address comes from datapath Adrout (= R[AA])
dmem_we  out  1  1=store R[SB] (Dout), 0=load
dmem_ack  in  1  data access complete
halted  out  1  sticky, set by HALT
pc  out  PC_W  current PC, for debug

Behaviour:
- Instruction format: op=IR[15:12], DR=IR[11:9], SA=IR[8:6], SB=IR[5:3], imm6=IR[5:0] (signed as branch offset).
- Opcodes and CTRWRD fields in EXEC:
  - 0 NOP: all fields 0.
  - 1 ADD: FS=0010.
  - 2 SUB: FS=0101.
  - 3 AND: FS=1000.
  - 4 OR: FS=1001.
  - 5 XOR: FS=1010.
  - 6 MOV: FS=0000.
  - For opcodes 1-6: DA=DR, AA=SA, BA=SB, MB=0, MD=0, RW=1.
  - 7 LDI: MB=1, FS=1100, DA=DR, RW=1, MD=0.
  - 8 LD, 9 ST: AA=SA, BA=SB (see MEM).
  - A BRZ, B BRN: AA=SA, FS=0000, RW=0. Z/N are sampled in EXEC.
  - C JMP: unconditional.
  - D HALT.
  - E-F: illegal, executed as NOP.
- States: FETCH -> DECODE -> EXEC -> (MEM) -> FETCH; HALT is terminal.
- FETCH:
  - imem_req=1, imem_addr=PC, held stable until imem_ack.
  - On the ack edge: IR<=imem_data, PC<=PC+1 (wraps mod 2^PC_W), go to DECODE.
  - Zero-wait ack in the same cycle is allowed (1-cycle FETCH).
- DECODE: one cycle, CTRWRD=0, registers opcode class.
- EXEC:
  - One cycle, CTRWRD driven per opcode.
  - Datapath commits on the EXEC->next edge when RW=1.
  - Branch taken: PC<=PC+sext(imm6), relative to the already-incremented PC, wraps.
  - Not taken: PC unchanged.
  - LD/ST go to MEM; HALT goes to HALT; all others go to FETCH.
- MEM (LD/ST):
  - dmem_req=1, dmem_we=(op==ST), AA=SA, BA=SB.
  - CTRWRD holds RW=0 until dmem_ack.
  - In the ack cycle for LD: MD=1, RW=1, DA=DR, so Din is written on that edge.
  - Go to FETCH on the ack edge; unbounded wait otherwise.
- HALT: halted=1, CTRWRD=0, no requests. Only reset exits.
- CTRWRD/Cin are combinational from state+IR; CTRWRD=16'h0000 in FETCH/DECODE/HALT.
- Cin={10'b0,IR[5:0]} always.
- Reset (async assert, sync-released by top level): state=FETCH, PC=RESET_VECTOR, IR=0, halted=0, imem_req/dmem_req=0 while asserted, CTRWRD=0.
- Reset mid-FETCH/MEM: the request drops immediately; a late ack after reset is ignored unless a new request is outstanding.
- V and C are unused in this revision and are ported for the future BRV/BRC opcodes.

Decomposition:
- Package ctrl_pkg:
  - state enum.
  - opcode constants (OP_NOP..OP_HALT).
  - FS codes (FS_A=0000, FS_ADD=0010, FS_SUB=0101, FS_AND=1000, FS_OR=1001, FS_XOR=1010, FS_B=1100).
  - CTRWRD field bit positions.
- One sub-module, ctrl_decode: combinational IR+state+ack -> CTRWRD, dmem_we, next-PC select.

Test Plan:
- Reset with RESET=0 mid-FETCH, then release -> PC=0, imem_req rises next cycle, CTRWRD=0x0000, halted=0.
- Fetch 0x7E05 (LDI R7,5) with 0 wait states -> EXEC CTRWRD=0xE071, Cin=0x0005, PC=1; datapath R7=0x0005.
- Fetch 0x1250 (ADD R1,R1,R2) with imem_ack delayed 3 cycles -> imem_addr stable; EXEC CTRWRD=0x2509.
- LD 0x8440 (LD R2,[R1]) with dmem_ack after 2 cycles -> dmem_req=1, dmem_we=0 for 3 cycles; ack-cycle CTRWRD has MD=1, RW=1, DA=2.
- BRZ with imm6=0x3E (-2) at PC=5 (incremented to 6): Z=1 -> PC=4; repeat with Z=0 -> PC=6.
- HALT 0xD000 -> halted=1 permanently, no further imem_req; async RESET=0 clears halted and PC.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared types and constants for the control sequencer: FSM state
//            encoding, opcodes, datapath function-select codes and the bit
//            layout of the 16-bit datapath control word.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Opcodes (IR[15:12]); 0xE and 0xF are illegal and behave as NOP
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BRZ  = 4'hA;
    localparam logic [3:0] OP_BRN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;

    // Datapath function-select codes
    localparam logic [3:0] FS_A   = 4'b0000;
    localparam logic [3:0] FS_ADD = 4'b0010;
    localparam logic [3:0] FS_SUB = 4'b0101;
    localparam logic [3:0] FS_AND = 4'b1000;
    localparam logic [3:0] FS_OR  = 4'b1001;
    localparam logic [3:0] FS_XOR = 4'b1010;
    localparam logic [3:0] FS_B   = 4'b1100;

    // Control word field positions: {DA,AA,BA,MB,FS,MD,RW}
    localparam int DA_LSB = 13;
    localparam int AA_LSB = 10;
    localparam int BA_LSB = 7;
    localparam int MB_BIT = 6;
    localparam int FS_LSB = 2;
    localparam int MD_BIT = 1;
    localparam int RW_BIT = 0;

    function automatic logic [15:0] make_ctrwrd(
        input logic [2:0] da,
        input logic [2:0] aa,
        input logic [2:0] ba,
        input logic       mb,
        input logic [3:0] fs,
        input logic       md,
        input logic       rw
    );
        logic [15:0] w_word;
        w_word                  = '0;
        w_word[DA_LSB +: 3]     = da;
        w_word[AA_LSB +: 3]     = aa;
        w_word[BA_LSB +: 3]     = ba;
        w_word[MB_BIT]          = mb;
        w_word[FS_LSB +: 4]     = fs;
        w_word[MD_BIT]          = md;
        w_word[RW_BIT]          = rw;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer_if
// Purpose  : Instruction-fetch and data-memory req/ack handshakes between the
//            sequencer (master) and the memory system (slave).
// Ports    : imem_req/imem_addr/imem_data/imem_ack - instruction fetch
//            dmem_req/dmem_we/dmem_ack               - data access
// Revision : 1.0 - initial release
// ============================================================================
interface control_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic            imem_ack;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_data, imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_data, imem_ack, dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Purpose  : Combinational decode of IR + FSM state (+ data ack) into the
//            datapath control word and the sequencing hints used by the FSM.
// Ports    : state, ir, dmem_ack, n, z   - inputs
//            ctrwrd                      - datapath control word
//            branch_taken                - EXEC-only: load PC with PC+offset
//            is_mem/is_store/is_halt     - opcode class of IR
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic        dmem_ack,
    input  logic        n,
    input  logic        z,
    output logic [15:0] ctrwrd,
    output logic        branch_taken,
    output logic        is_mem,
    output logic        is_store,
    output logic        is_halt
);
    logic [3:0] w_op;
    logic [2:0] w_dr;
    logic [2:0] w_sa;
    logic [2:0] w_sb;
    logic       w_ld_commit;

    assign w_op     = ir[15:12];
    assign w_dr     = ir[11:9];
    assign w_sa     = ir[8:6];
    assign w_sb     = ir[5:3];

    assign is_mem   = (w_op == OP_LD) || (w_op == OP_ST);
    assign is_store = (w_op == OP_ST);
    assign is_halt  = (w_op == OP_HALT);

    // A load writes memory data back into DR only on the cycle the ack arrives
    assign w_ld_commit = (w_op == OP_LD) && dmem_ack;

    always_comb begin
        ctrwrd       = '0;
        branch_taken = 1'b0;
        case (state)
            ST_EXEC: begin
                case (w_op)
                    OP_NOP: ;
                    OP_ADD: ctrwrd = make_ctrwrd(w_dr, w_sa, w_sb, 1'b0, FS_ADD, 1'b0, 1'b1);
                    OP_SUB: ctrwrd = make_ctrwrd(w_dr, w_sa, w_sb, 1'b0, FS_SUB, 1'b0, 1'b1);
                    OP_AND: ctrwrd = make_ctrwrd(w_dr, w_sa, w_sb, 1'b0, FS_AND, 1'b0, 1'b1);
                    OP_OR:  ctrwrd = make_ctrwrd(w_dr, w_sa, w_sb, 1'b0, FS_OR,  1'b0, 1'b1);
                    OP_XOR: ctrwrd = make_ctrwrd(w_dr, w_sa, w_sb, 1'b0, FS_XOR, 1'b0, 1'b1);
                    OP_MOV: ctrwrd = make_ctrwrd(w_dr, w_sa, w_sb, 1'b0, FS_A,   1'b0, 1'b1);
                    OP_LDI: ctrwrd = make_ctrwrd(w_dr, 3'd0, 3'd0, 1'b1, FS_B,   1'b0, 1'b1);
                    OP_LD, OP_ST:
                            ctrwrd = make_ctrwrd(3'd0, w_sa, w_sb, 1'b0, FS_A,   1'b0, 1'b0);
                    // Route R[SA] through the ALU so the datapath flags reflect it
                    OP_BRZ: begin
                        ctrwrd       = make_ctrwrd(3'd0, w_sa, 3'd0, 1'b0, FS_A, 1'b0, 1'b0);
                        branch_taken = z;
                    end
                    OP_BRN: begin
                        ctrwrd       = make_ctrwrd(3'd0, w_sa, 3'd0, 1'b0, FS_A, 1'b0, 1'b0);
                        branch_taken = n;
                    end
                    OP_JMP: branch_taken = 1'b1;
                    default: ;
                endcase
            end
            ST_MEM: begin
                ctrwrd = make_ctrwrd(w_ld_commit ? w_dr : 3'd0, w_sa, w_sb, 1'b0, FS_A,
                                     w_ld_commit, w_ld_commit);
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM sequencer producing the
//            datapath control word and constant, with req/ack instruction and
//            data-memory ports and a terminal HALT state.
// Ports    : CLK, RESET (async, active low)
//            bus     - imem/dmem handshakes (master side)
//            CTRWRD  - datapath control word, Cin - zero-extended IR[5:0]
//            V,C,N,Z - datapath status flags
//            halted  - sticky halt indicator, pc - current program counter
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int PC_W         = 8,
    parameter int RESET_VECTOR = 0
) (
    input  logic                CLK,
    input  logic                RESET,
    control_sequencer_if.master bus,
    output logic [15:0]         CTRWRD,
    output logic [15:0]         Cin,
    input  logic                V,
    input  logic                C,
    input  logic                N,
    input  logic                Z,
    output logic                halted,
    output logic [PC_W-1:0]     pc
);
    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic            r_halted;
    logic            r_imem_req;
    logic            r_dmem_req;
    logic            r_dmem_we;

    logic            w_fetch_ack;
    logic [PC_W-1:0] w_offset;
    logic            w_branch_taken;
    logic            w_is_mem;
    logic            w_is_store;
    logic            w_is_halt;

    // V/C are reserved for future overflow/carry branches
    logic            w_unused_vc;
    assign w_unused_vc = V ^ C;

    // An ack only counts while our own request is up; stale acks are dropped
    assign w_fetch_ack = r_imem_req & bus.imem_ack;
    assign w_offset    = PC_W'($signed(r_ir[5:0]));

    ctrl_decode u_decode (
        .state        (r_state),
        .ir           (r_ir),
        .dmem_ack     (bus.dmem_ack),
        .n            (N),
        .z            (Z),
        .ctrwrd       (CTRWRD),
        .branch_taken (w_branch_taken),
        .is_mem       (w_is_mem),
        .is_store     (w_is_store),
        .is_halt      (w_is_halt)
    );

    assign Cin           = {10'b0, r_ir[5:0]};
    assign halted        = r_halted;
    assign pc            = r_pc;
    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_pc;
    assign bus.dmem_req  = r_dmem_req;
    assign bus.dmem_we   = r_dmem_we;

    // Requests are registered and raised on the same edge that enters
    // FETCH/MEM, so a zero-wait ack completes FETCH in a single cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_FETCH;
            r_pc       <= PC_W'(RESET_VECTOR);
            r_ir       <= '0;
            r_halted   <= 1'b0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_imem_req <= 1'b1;
                    if (w_fetch_ack) begin
                        r_ir       <= bus.imem_data;
                        r_pc       <= r_pc + PC_W'(1);
                        r_imem_req <= 1'b0;
                        r_state    <= ST_DECODE;
                    end
                end
                ST_DECODE: r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (w_branch_taken) begin
                        r_pc <= r_pc + w_offset;
                    end
                    if (w_is_mem) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= w_is_store;
                        r_state    <= ST_MEM;
                    end else if (w_is_halt) begin
                        r_halted   <= 1'b1;
                        r_state    <= ST_HALT;
                    end else begin
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (bus.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Self-checking bench for control_sequencer: directed vector table,
//            reset/halt corner sequences and random instruction streams
//            checked against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] ctrwrd;
    logic [15:0] cin;
    logic        v, c, n, z;
    logic        halted;
    logic [7:0]  pc;

    always #5 clk = ~clk;

    control_sequencer_if #(.PC_W(8)) bus ();

    control_sequencer #(.PC_W(8), .RESET_VECTOR(0)) dut (
        .CLK    (clk),
        .RESET  (reset_n),
        .bus    (bus.master),
        .CTRWRD (ctrwrd),
        .Cin    (cin),
        .V      (v),
        .C      (c),
        .N      (n),
        .Z      (z),
        .halted (halted),
        .pc     (pc)
    );

    int checks = 0;
    int errors = 0;
    int m_pc   = 0;

    typedef struct {
        logic [15:0] instr;
        bit          n;
        bit          z;
        int          iwait;
        int          dwait;
        logic [15:0] exp_exec;
        logic [15:0] exp_memack;
        int          pc_adj;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [15:0] instr, input bit vn, input bit vz,
                           input int iw, input int dw, input logic [15:0] e,
                           input logic [15:0] m, input int adj);
        vec_t vv;
        vv.instr = instr; vv.n = vn; vv.z = vz; vv.iwait = iw; vv.dwait = dw;
        vv.exp_exec = e; vv.exp_memack = m; vv.pc_adj = adj;
        vecs.push_back(vv);
    endtask

    // ---------------- reference model (instruction level) ----------------
    function automatic int alu_fs(input int op);
        case (op)
            1: return 2;  2: return 5;  3: return 8;
            4: return 9;  5: return 10; default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] ref_exec(input logic [15:0] instr);
        int op, dr, sa, sb;
        op = int'(instr[15:12]); dr = int'(instr[11:9]);
        sa = int'(instr[8:6]);   sb = int'(instr[5:3]);
        if (op >= 1 && op <= 6) return 16'(dr * 8192 + sa * 1024 + sb * 128 + alu_fs(op) * 4 + 1);
        if (op == 7)            return 16'(dr * 8192 + 64 + 12 * 4 + 1);
        if (op == 8 || op == 9) return 16'(sa * 1024 + sb * 128);
        if (op == 10 || op == 11) return 16'(sa * 1024);
        return 16'h0000;
    endfunction

    function automatic logic [15:0] ref_memack(input logic [15:0] instr);
        int dr, sa, sb;
        dr = int'(instr[11:9]); sa = int'(instr[8:6]); sb = int'(instr[5:3]);
        if (instr[15:12] == 4'h8) return 16'(dr * 8192 + sa * 1024 + sb * 128 + 2 + 1);
        return 16'(sa * 1024 + sb * 128);
    endfunction

    function automatic int ref_adj(input logic [15:0] instr, input bit fn, input bit fz);
        int off;
        off = int'(instr[5:0]);
        if (instr[5]) off = off - 64;
        case (int'(instr[15:12]))
            10: return fz ? off : 0;
            11: return fn ? off : 0;
            12: return off;
            default: return 0;
        endcase
    endfunction

    // Runs one instruction through FETCH..EXEC(..MEM); returns at the
    // negedge after the instruction has retired.
    task automatic do_instr(input logic [15:0] instr, input int iwait, input int dwait,
                            input bit fn, input bit fz,
                            output logic [15:0] got_exec, output logic [15:0] got_memack);
        int         cnt;
        logic [7:0] addr0;
        bit         is_mem;
        got_exec   = '0;
        got_memack = '0;
        is_mem     = (instr[15:12] == 4'h8) || (instr[15:12] == 4'h9);
        cnt = 0;
        while (bus.imem_req !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("fetch_req", {31'b0, bus.imem_req}, 32'd1);
        if (bus.imem_req !== 1'b1) return;
        check("fetch_addr", {24'b0, bus.imem_addr}, m_pc);
        addr0 = bus.imem_addr;
        repeat (iwait) @(negedge clk);
        if (iwait > 0) check("addr_stable", {24'b0, bus.imem_addr}, {24'b0, addr0});
        bus.imem_data = instr;
        bus.imem_ack  = 1'b1;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        bus.imem_data = 16'($urandom);
        check("decode_ctrl", {16'b0, ctrwrd}, 32'd0);
        n = fn;
        z = fz;
        @(negedge clk);
        got_exec = ctrwrd;
        check("cin", {16'b0, cin}, {26'b0, instr[5:0]});
        @(negedge clk);
        n = 1'b0;
        z = 1'b0;
        if (is_mem) begin
            for (int i = 0; i <= dwait; i++) begin
                check("dmem_req", {31'b0, bus.dmem_req}, 32'd1);
                check("dmem_we", {31'b0, bus.dmem_we}, {31'b0, instr[12]});
                if (i < dwait) begin
                    check("mem_wait_ctrl", {16'b0, ctrwrd}, {16'b0, ref_exec(instr)});
                    @(negedge clk);
                end
            end
            bus.dmem_ack = 1'b1;
            #1;
            got_memack = ctrwrd;
            @(negedge clk);
            bus.dmem_ack = 1'b0;
        end
    endtask

    task automatic run_and_check(input logic [15:0] instr, input int iw, input int dw,
                                 input bit fn, input bit fz, input logic [15:0] e,
                                 input logic [15:0] m, input int adj);
        logic [15:0] ge, gm;
        do_instr(instr, iw, dw, fn, fz, ge, gm);
        check("exec_ctrl", {16'b0, ge}, {16'b0, e});
        if (instr[15:12] == 4'h8 || instr[15:12] == 4'h9)
            check("memack_ctrl", {16'b0, gm}, {16'b0, m});
        m_pc = (m_pc + 1 + adj) & 255;
        check("pc", {24'b0, pc}, m_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] instr;
        bit          rn, rz, saw;
        int          cnt;

        reset_n = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_data = '0; bus.dmem_ack = 1'b0;
        v = 1'b0; c = 1'b0; n = 1'b0; z = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        check("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        check("rst_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
        check("rst_ctrwrd", {16'b0, ctrwrd}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_pc", {24'b0, pc}, 32'd0);
        reset_n = 1'b1;
        check("req_before_edge", {31'b0, bus.imem_req}, 32'd0);
        @(negedge clk);
        check("req_after_release", {31'b0, bus.imem_req}, 32'd1);

        // ---------------- reset mid-FETCH with a late ack ----------------
        #2 reset_n = 1'b0;
        #1;
        check("midfetch_req_drop", {31'b0, bus.imem_req}, 32'd0);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 16'h7E05;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("late_ack_pc", {24'b0, pc}, 32'd0);
        check("late_ack_ctrl", {16'b0, ctrwrd}, 32'd0);
        check("late_ack_req", {31'b0, bus.imem_req}, 32'd1);
        m_pc = 0;

        // ---------------- directed vector table ----------------
        add_vec(16'h7E05, 0, 0, 0, 0, 16'hE071, 16'h0000, 0);
        add_vec(16'h1250, 0, 0, 3, 0, 16'h2509, 16'h0000, 0);
        add_vec(16'h2A98, 0, 0, 1, 0, 16'hA995, 16'h0000, 0);
        add_vec(16'h3728, 0, 0, 0, 0, 16'h72A1, 16'h0000, 0);
        add_vec(16'h4C08, 0, 0, 2, 0, 16'hC0A5, 16'h0000, 0);
        add_vec(16'h51FF, 0, 0, 0, 0, 16'h1FA9, 16'h0000, 0);
        add_vec(16'h6E40, 0, 0, 1, 0, 16'hE401, 16'h0000, 0);
        add_vec(16'h0FFF, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
        add_vec(16'hEFFF, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
        add_vec(16'hFFFF, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
        add_vec(16'h8440, 0, 0, 0, 2, 16'h0400, 16'h4403, 0);
        add_vec(16'h9458, 0, 0, 0, 0, 16'h0580, 16'h0580, 0);
        add_vec(16'hA07E, 0, 1, 0, 0, 16'h0400, 16'h0000, -2);
        add_vec(16'hA07E, 1, 0, 0, 0, 16'h0400, 16'h0000, 0);
        add_vec(16'hB043, 1, 0, 0, 0, 16'h0400, 16'h0000, 3);
        add_vec(16'hB043, 0, 1, 0, 0, 16'h0400, 16'h0000, 0);
        add_vec(16'hC005, 0, 0, 0, 0, 16'h0000, 16'h0000, 5);
        add_vec(16'hC03F, 0, 0, 0, 0, 16'h0000, 16'h0000, -1);
        foreach (vecs[i])
            run_and_check(vecs[i].instr, vecs[i].iwait, vecs[i].dwait, vecs[i].n, vecs[i].z,
                          vecs[i].exp_exec, vecs[i].exp_memack, vecs[i].pc_adj);

        // ---------------- reset mid-MEM with a late data ack ----------------
        cnt = 0;
        while (bus.imem_req !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        check("mm_fetch_req", {31'b0, bus.imem_req}, 32'd1);
        bus.imem_data = 16'h8440;
        bus.imem_ack  = 1'b1;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        repeat (2) @(negedge clk);
        check("mm_dmem_req", {31'b0, bus.dmem_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mm_dmem_req_drop", {31'b0, bus.dmem_req}, 32'd0);
        check("mm_ctrl_rst", {16'b0, ctrwrd}, 32'd0);
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mm_late_ack_ctrl", {16'b0, ctrwrd}, 32'd0);
        check("mm_late_ack_pc", {24'b0, pc}, 32'd0);
        check("mm_no_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
        bus.dmem_ack = 1'b0;
        m_pc = 0;

        // ---------------- random instruction stream ----------------
        for (int k = 0; k < 250; k++) begin
            instr = 16'($urandom);
            if (instr[15:12] == 4'hD) instr[15:12] = 4'h0;
            rn = 1'($urandom_range(0, 1));
            rz = 1'($urandom_range(0, 1));
            run_and_check(instr, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                          rn, rz, ref_exec(instr), ref_memack(instr), ref_adj(instr, rn, rz));
        end

        // ---------------- HALT and recovery by reset ----------------
        run_and_check(16'hD000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0);
        check("halted_set", {31'b0, halted}, 32'd1);
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || halted !== 1'b1 || ctrwrd !== 16'h0)
                saw = 1'b1;
        end
        check("halt_quiet", {31'b0, saw}, 32'd0);
        check("halt_pc_hold", {24'b0, pc}, m_pc);
        #2 reset_n = 1'b0;
        #1;
        check("halt_rst_cleared", {31'b0, halted}, 32'd0);
        check("halt_rst_pc", {24'b0, pc}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("restart_req", {31'b0, bus.imem_req}, 32'd1);
        m_pc = 0;
        run_and_check(16'h7E05, 0, 0, 0, 0, 16'hE071, 16'h0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
